// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, parity modes
// and the parity-reduce helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Even parity is the plain XOR of the word; odd parity inverts it.
  function automatic logic parity_reduce(input logic [63:0] word, input logic odd);
    return odd ^ (^word);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..TICKS_PER_BIT-1 and flags the last cycle of
// each bit; restart holds it at zero.
module uart_baud_tick #(
  parameter int unsigned TICKS_PER_BIT = 87,
  localparam int unsigned CW = $clog2(TICKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic          tick_c
);

  assign tick_c = (count == CW'(TICKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick_c) count <= '0;
    else                          count <= count + CW'(1);
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with an AXI-Stream style input; one word per
// frame, all line-side outputs registered.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH   = 64,
  parameter int unsigned TICKS_PER_BIT = 87,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned LSB_FIRST     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] s_axis_tx_tdata,
  input  logic                   s_axis_tx_tvalid,
  output logic                   s_axis_tx_tready,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done
);

  localparam int unsigned BCW = $clog2(FRAME_WIDTH + 1);
  localparam int unsigned CW  = $clog2(TICKS_PER_BIT);

  if (FRAME_WIDTH < 1 || FRAME_WIDTH > 64) begin : g_bad_width
    $error("uart_tx_cfg: FRAME_WIDTH must be 1..64");
  end
  if (TICKS_PER_BIT < 2 || TICKS_PER_BIT > 511) begin : g_bad_ticks
    $error("uart_tx_cfg: TICKS_PER_BIT must be 2..511");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (LSB_FIRST > 1) begin : g_bad_order
    $error("uart_tx_cfg: LSB_FIRST must be 0 or 1");
  end

  state_t                 state, next_state;
  logic [FRAME_WIDTH-1:0] data_q;
  logic [FRAME_WIDTH-1:0] bit_mask;
  logic [BCW-1:0]         bit_cnt, bit_cnt_d;
  logic                   stop_cnt, stop_cnt_d;
  logic [CW-1:0]          count;
  logic                   tick;
  logic                   xfer, last_bit, last_stop, data_bit;
  logic                   tx_d, tready_d, busy_d, done_d;

  uart_baud_tick #(.TICKS_PER_BIT(TICKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == ST_IDLE),
    .count   (count),
    .tick_c  (tick)
  );

  assign xfer      = (state == ST_IDLE) && s_axis_tx_tvalid && s_axis_tx_tready;
  assign last_bit  = (bit_cnt == BCW'(FRAME_WIDTH - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a second stop bit re-enters STOP
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (xfer) next_state = ST_START;
      ST_START:  if (tick) next_state = ST_DATA;
      ST_DATA:   if (tick && last_bit)
                   next_state = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) next_state = ST_STOP;
      ST_STOP:   if (tick && last_stop) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Bit and stop counters both wrap to zero when their phase ends
  always_comb begin
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    if (state == ST_DATA && tick) bit_cnt_d = last_bit ? '0 : bit_cnt + BCW'(1);
    if (state == ST_STOP && tick) stop_cnt_d = last_stop ? 1'b0 : 1'b1;
  end

  // Data bit for the cycle being registered, selected by the next bit index
  always_comb begin
    if (LSB_FIRST != 0) bit_mask = FRAME_WIDTH'(1) >> 0 << bit_cnt_d;
    else                bit_mask = (FRAME_WIDTH'(1) << (FRAME_WIDTH - 1)) >> bit_cnt_d;
    data_bit = |(data_q & bit_mask);
  end

  // Output logic: decode from next state so the flops line up with the state
  always_comb begin
    tx_d     = 1'b1;
    tready_d = 1'b0;
    busy_d   = 1'b1;
    done_d   = (state == ST_STOP) && last_stop && (count == CW'(TICKS_PER_BIT - 2));
    unique case (next_state)
      ST_IDLE: begin
        tready_d = 1'b1;
        busy_d   = 1'b0;
      end
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_bit;
      ST_PARITY: tx_d = parity_reduce(64'(data_q), PARITY == PARITY_ODD);
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q           <= '0;
      bit_cnt          <= '0;
      stop_cnt         <= 1'b0;
      tx               <= 1'b1;
      s_axis_tx_tready <= 1'b0;
      busy             <= 1'b0;
      tx_done          <= 1'b0;
    end else begin
      if (xfer) data_q <= s_axis_tx_tdata;
      bit_cnt          <= bit_cnt_d;
      stop_cnt         <= stop_cnt_d;
      tx               <= tx_d;
      s_axis_tx_tready <= tready_d;
      busy             <= busy_d;
      tx_done          <= done_d;
    end
  end

endmodule
